// File: rtl/n_to_one_stream_mux.sv
// N-to-1 valid/ready stream multiplexer with a one-word registered output stage.
// MODE=0 steers from Select_Line; MODE=1 arbitrates round-robin across valid channels.
module n_to_one_stream_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int MODE     = 0
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic [CHANNELS*WIDTH-1:0]   In_Data,
    input  logic [CHANNELS-1:0]         In_Valid,
    output logic [CHANNELS-1:0]         In_Ready,
    input  logic [$clog2(CHANNELS)-1:0] Select_Line,
    output logic [WIDTH-1:0]            Out_Data,
    output logic                        Out_Valid,
    input  logic                        Out_Ready,
    output logic [$clog2(CHANNELS)-1:0] Out_Channel
);

    localparam int SEL_W = $clog2(CHANNELS);

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic             can_load;
    logic             in_xfer;
    logic [WIDTH-1:0] grant_data;
    logic [SEL_W-1:0] idx;

    assign can_load = ~Out_Valid | Out_Ready;
    assign in_xfer  = can_load & grant_valid & Reset_n;

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = '0;
        if (MODE == 0) begin
            grant = Select_Line;
            if (int'(Select_Line) < CHANNELS) grant_valid = In_Valid[Select_Line];
        end else begin
            // Walk the search order backwards so the first valid channel from rr_ptr wins last.
            for (int i = CHANNELS - 1; i >= 0; i--) begin
                idx = SEL_W'((int'(rr_ptr) + i) % CHANNELS);
                if (In_Valid[idx]) begin
                    grant       = idx;
                    grant_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        In_Ready   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (grant == SEL_W'(k)) begin
                grant_data  = In_Data[k*WIDTH +: WIDTH];
                In_Ready[k] = can_load & grant_valid & Reset_n;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    // NOTE: reset clears every output-stage register, so a held word is discarded rather than delivered.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Out_Valid   <= 1'b0;
            Out_Data    <= '0;
            Out_Channel <= '0;
            rr_ptr      <= '0;
        end else if (in_xfer) begin
            Out_Valid   <= 1'b1;
            Out_Data    <= grant_data;
            Out_Channel <= grant;
            if (MODE != 0) rr_ptr <= (grant == SEL_W'(CHANNELS - 1)) ? '0 : grant + 1'b1;
        end else if (Out_Ready) begin
            Out_Valid <= 1'b0;
        end
    end

endmodule
